// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: measures meas_clk rising edges per refclk gate window and qualifies frequency lock
module clk_freq_monitor #(
  parameter int GATE_CYCLES   = 50000,
  parameter int EXP_COUNT     = 2000,
  parameter int TOL           = 20,
  parameter int LOCK_WINDOWS  = 4,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             i_refclk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_pll_locked,
  input  logic             i_meas_clk,
  input  logic             i_fail_clear,
  output logic [CNT_W-1:0] o_meas_count,
  output logic             o_count_valid,
  output logic             o_in_range,
  output logic             o_mon_locked,
  output logic             o_fail_sticky
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} state_t;
  state_t           r_state;
  logic [2:0]       r_mclk_s;
  logic [1:0]       r_lock_s;
  logic [SW-1:0]    r_settle;
  logic [GW-1:0]    r_gate;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [LW-1:0]    r_good;
  logic             w_edge, w_lock, w_in;
  logic [CNT_W:0]   w_cnt, w_exp, w_dev;
  assign w_edge = r_mclk_s[1] & ~r_mclk_s[2];
  assign w_lock = r_lock_s[1];
  // deviation is formed one bit wider so a zero count cannot wrap into range
  assign w_cnt  = {1'b0, r_edge_cnt};
  assign w_exp  = (CNT_W+1)'(EXP_COUNT);
  assign w_dev  = (w_cnt >= w_exp) ? w_cnt - w_exp : w_exp - w_cnt;
  assign w_in   = w_dev <= (CNT_W+1)'(TOL);
  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_mclk_s      <= '0;
      r_lock_s      <= '0;
      r_settle      <= '0;
      r_gate        <= '0;
      r_edge_cnt    <= '0;
      r_good        <= '0;
      o_meas_count  <= '0;
      o_count_valid <= 1'b0;
      o_in_range    <= 1'b0;
      o_mon_locked  <= 1'b0;
      o_fail_sticky <= 1'b0;
    end else begin
      r_mclk_s      <= {r_mclk_s[1:0], i_meas_clk};
      r_lock_s      <= {r_lock_s[0], i_pll_locked};
      o_count_valid <= 1'b0;
      if (r_good == LW'(LOCK_WINDOWS)) o_mon_locked <= 1'b1;
      if (i_fail_clear) o_fail_sticky <= 1'b0;
      if (!i_enable) begin
        r_state      <= IDLE;
        r_settle     <= '0;
        r_good       <= '0;
        o_mon_locked <= 1'b0;
      end else if ((r_state == MEASURE || r_state == EVAL) && !w_lock) begin
        r_state      <= SETTLE;
        r_settle     <= '0;
        r_good       <= '0;
        o_mon_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SETTLE;
            r_settle <= '0;
          end
          SETTLE: begin
            if (!w_lock) r_settle <= '0;
            else if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
              r_state    <= MEASURE;
              r_gate     <= GW'(GATE_CYCLES - 1);
              r_edge_cnt <= '0;
            end else r_settle <= r_settle + 1'b1;
          end
          MEASURE: begin
            if (w_edge && !(&r_edge_cnt)) r_edge_cnt <= r_edge_cnt + 1'b1;
            if (r_gate == '0) r_state <= EVAL;
            else r_gate <= r_gate - 1'b1;
          end
          EVAL: begin
            o_meas_count  <= r_edge_cnt;
            o_count_valid <= 1'b1;
            o_in_range    <= w_in;
            r_gate        <= GW'(GATE_CYCLES - 1);
            r_edge_cnt    <= '0;
            r_state       <= MEASURE;
            if (w_in) r_good <= (r_good == LW'(LOCK_WINDOWS)) ? r_good : r_good + 1'b1;
            else begin
              r_good        <= '0;
              o_mon_locked  <= 1'b0;
              o_fail_sticky <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor: scenario tasks with a window scoreboard for clk_freq_monitor
`timescale 1ns/1ps
module tb_clk_freq_monitor;
  localparam int CW = 16;
  logic refclk = 0, rst_n = 0, enable = 0, pll_locked = 0, meas_clk = 0, fail_clear = 0;
  logic [CW-1:0] meas_count;
  logic count_valid, in_range, mon_locked, fail_sticky;
  int checks = 0, failures = 0;
  real mper = 500.0;
  typedef struct {int lo; int hi; bit rng;} exp_t;
  exp_t sb[$];

  clk_freq_monitor #(.GATE_CYCLES(1000), .EXP_COUNT(40), .TOL(1), .LOCK_WINDOWS(2),
                     .SETTLE_CYCLES(16), .CNT_W(CW)) dut (
    .i_refclk(refclk), .i_rst_n(rst_n), .i_enable(enable), .i_pll_locked(pll_locked),
    .i_meas_clk(meas_clk), .i_fail_clear(fail_clear), .o_meas_count(meas_count),
    .o_count_valid(count_valid), .o_in_range(in_range), .o_mon_locked(mon_locked),
    .o_fail_sticky(fail_sticky));

  always #10 refclk = ~refclk;
  always begin
    if (mper == 0.0) begin meas_clk = 0; #10; end
    else #(mper / 2.0) meas_clk = ~meas_clk;
  end
  initial begin #3ms; $display("FAIL global_timeout: simulation did not finish"); $fatal(1); end

  task automatic cycles(input int k);
    repeat (k) @(negedge refclk);
  endtask

  task automatic wait_valid(input int budget, output bit got, output int n);
    got = 0; n = 0;
    while (!got && n < budget) begin @(negedge refclk); n++; got = count_valid; end
  endtask

  task automatic test_reset;
    rst_n = 0; enable = 0; pll_locked = 1; mper = 500.0;
    cycles(5);
    checks++; if (meas_count !== 0) begin failures++; $display("FAIL rst_count: got %0d want 0", meas_count); end
    checks++; if (count_valid !== 0) begin failures++; $display("FAIL rst_valid: got %b want 0", count_valid); end
    checks++; if (in_range !== 0) begin failures++; $display("FAIL rst_range: got %b want 0", in_range); end
    checks++; if (mon_locked !== 0) begin failures++; $display("FAIL rst_locked: got %b want 0", mon_locked); end
    checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL rst_sticky: got %b want 0", fail_sticky); end
    rst_n = 1; cycles(5);
  endtask

  task automatic test_nominal;
    bit got; int n; exp_t e;
    repeat (2) sb.push_back('{39, 41, 1'b1});
    enable = 1;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, got, n); e = sb.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL nom_valid%0d: none in %0d cycles", w, n); end
      if (w == 0) begin
        checks++; if (n < 1015 || n > 1022) begin failures++; $display("FAIL nom_latency: got %0d want 1015..1022", n); end
      end
      checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL nom_count%0d: got %0d want %0d..%0d", w, meas_count, e.lo, e.hi); end
      checks++; if (in_range !== e.rng) begin failures++; $display("FAIL nom_range%0d: got %b want %b", w, in_range, e.rng); end
      checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL nom_sticky%0d: got %b want 0", w, fail_sticky); end
      cycles(1);
      checks++; if (count_valid !== 0) begin failures++; $display("FAIL nom_pulse%0d: got %b want 0", w, count_valid); end
      if (w == 0) begin
        checks++; if (mon_locked !== 0) begin failures++; $display("FAIL nom_early_lock: got %b want 0", mon_locked); end
      end
    end
    cycles(1);
    checks++; if (mon_locked !== 1) begin failures++; $display("FAIL nom_lock: got %b want 1", mon_locked); end
  endtask

  task automatic test_pll_loss;
    bit got, fell; int n; exp_t e;
    cycles(300);
    pll_locked = 0; fell = 0;
    for (int k = 0; k < 3; k++) begin @(negedge refclk); if (mon_locked === 0) fell = 1; end
    checks++; if (!fell) begin failures++; $display("FAIL loss_unlock: mon_locked=%b want 0 within 3 cycles", mon_locked); end
    cycles(2); pll_locked = 1;
    repeat (2) sb.push_back('{39, 41, 1'b1});
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, got, n); e = sb.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL loss_valid%0d: none in %0d cycles", w, n); end
      if (w == 0) begin
        checks++; if (n < 1015 || n > 1025) begin failures++; $display("FAIL loss_relock_delay: got %0d want 1015..1025", n); end
      end
      checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL loss_count%0d: got %0d want %0d..%0d", w, meas_count, e.lo, e.hi); end
      checks++; if (in_range !== e.rng) begin failures++; $display("FAIL loss_range%0d: got %b want %b", w, in_range, e.rng); end
    end
    cycles(2);
    checks++; if (mon_locked !== 1) begin failures++; $display("FAIL loss_relock: got %b want 1", mon_locked); end
  endtask

  task automatic test_wrong_freq;
    bit got; int n; exp_t e;
    enable = 0; mper = 1000.0 / 3.0; cycles(20);
    repeat (2) sb.push_back('{59, 61, 1'b0});
    enable = 1;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, got, n); e = sb.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL wf_valid%0d: none in %0d cycles", w, n); end
      checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL wf_count%0d: got %0d want %0d..%0d", w, meas_count, e.lo, e.hi); end
      checks++; if (in_range !== e.rng) begin failures++; $display("FAIL wf_range%0d: got %b want %b", w, in_range, e.rng); end
      checks++; if (fail_sticky !== 1) begin failures++; $display("FAIL wf_sticky%0d: got %b want 1", w, fail_sticky); end
      checks++; if (mon_locked !== 0) begin failures++; $display("FAIL wf_lock%0d: got %b want 0", w, mon_locked); end
      if (w == 0) begin
        fail_clear = 1; cycles(1); fail_clear = 0;
        checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL wf_clear: got %b want 0", fail_sticky); end
      end
    end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    sb.push_back('{59, 61, 1'b0});
    for (int i = 1; i <= 1000; i++) begin
      @(negedge refclk);
      if (i == 10) fail_clear = 1;
      if (i == 11) begin
        fail_clear = 0;
        checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL sim_preclear: got %b want 0", fail_sticky); end
      end
    end
    fail_clear = 1; cycles(1); fail_clear = 0;
    e = sb.pop_front();
    checks++; if (count_valid !== 1) begin failures++; $display("FAIL sim_eval_align: count_valid=%b want 1", count_valid); end
    checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL sim_count: got %0d want %0d..%0d", meas_count, e.lo, e.hi); end
    checks++; if (fail_sticky !== 1) begin failures++; $display("FAIL sim_sticky: got %b want 1", fail_sticky); end
  endtask

  task automatic test_stuck;
    bit got; int n; exp_t e;
    enable = 0; mper = 0.0; cycles(20);
    fail_clear = 1; cycles(1); fail_clear = 0;
    checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL stk_clear: got %b want 0", fail_sticky); end
    sb.push_back('{0, 0, 1'b0});
    enable = 1;
    wait_valid(1100, got, n); e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL stk_valid: none in %0d cycles", n); end
    checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL stk_count: got %0d want %0d", meas_count, e.lo); end
    checks++; if (in_range !== e.rng) begin failures++; $display("FAIL stk_range: got %b want %b", in_range, e.rng); end
    checks++; if (fail_sticky !== 1) begin failures++; $display("FAIL stk_sticky: got %b want 1", fail_sticky); end
  endtask

  task automatic test_enable_low;
    bit got; int n; exp_t e;
    enable = 0; mper = 500.0; cycles(20);
    repeat (2) sb.push_back('{39, 41, 1'b1});
    enable = 1;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, got, n); e = sb.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL en_valid%0d: none in %0d cycles", w, n); end
      checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL en_count%0d: got %0d want %0d..%0d", w, meas_count, e.lo, e.hi); end
    end
    cycles(2);
    checks++; if (mon_locked !== 1) begin failures++; $display("FAIL en_lock: got %b want 1", mon_locked); end
    enable = 0; cycles(2);
    checks++; if (mon_locked !== 0) begin failures++; $display("FAIL en_unlock: got %b want 0", mon_locked); end
    checks++; if (fail_sticky !== 1) begin failures++; $display("FAIL en_sticky: got %b want 1", fail_sticky); end
    checks++; if (in_range !== 1) begin failures++; $display("FAIL en_range_hold: got %b want 1", in_range); end
  endtask

  task automatic test_reset_mid;
    bit got; int n; exp_t e;
    sb.push_back('{39, 41, 1'b1});
    enable = 1;
    wait_valid(1100, got, n); e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL rm_valid: none in %0d cycles", n); end
    checks++; if (meas_count < e.lo || meas_count > e.hi) begin failures++; $display("FAIL rm_count: got %0d want %0d..%0d", meas_count, e.lo, e.hi); end
    cycles(200);
    rst_n = 0; cycles(1);
    checks++; if (meas_count !== 0) begin failures++; $display("FAIL rm_count_clr: got %0d want 0", meas_count); end
    checks++; if (in_range !== 0) begin failures++; $display("FAIL rm_range_clr: got %b want 0", in_range); end
    checks++; if (fail_sticky !== 0) begin failures++; $display("FAIL rm_sticky_clr: got %b want 0", fail_sticky); end
    checks++; if (mon_locked !== 0 || count_valid !== 0) begin failures++; $display("FAIL rm_flags_clr: locked=%b valid=%b want 0 0", mon_locked, count_valid); end
    rst_n = 1; cycles(2);
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_pll_loss;
    test_wrong_freq;
    test_simultaneous;
    test_stuck;
    test_enable_low;
    test_reset_mid;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: %0d left want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
